instr_encoder_loader: RTL and testbench

INSTR_ENCODER_LOADER -- requirements
Module: instr_encoder_loader

---
 rtl/instr_encoder_loader.sv | 84 ++++++++
 tb/tb_instr_encoder_loader.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes R/I/J field tuples into 32-bit words and writes them to consecutive instruction-memory addresses
// Ports: clk, rst_n (async active-low); start/base_addr/count begin a load; in_valid/in_ready handshake a tuple
// (fmt, opcode, fcode, reg1, reg2, shamt, imm, label); wr_en/wr_addr/wr_data drive the memory write;
// busy (LOAD), done (DONE pulse), err (sticky illegal tuple), words_written (writes this load).
// Optional macro INSTR_ENC_CHECK_EN rejects tuples whose unused register/shamt fields are non-zero.
module instr_encoder_loader (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [9:0]  base_addr,
  input  logic [9:0]  count,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  fmt,
  input  logic [3:0]  opcode,
  input  logic [3:0]  fcode,
  input  logic [4:0]  reg1,
  input  logic [4:0]  reg2,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] label,
  output logic        wr_en,
  output logic [9:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [9:0]  words_written
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state, state_nx;
  logic [9:0] base, rem;
  logic [31:0] enc;
  logic xfer, legal;
  assign in_ready = state == LOAD && rem != 10'd0;
  assign busy = state == LOAD;
  assign done = state == DONE;
  assign xfer = in_valid && in_ready;
  always_comb begin
    enc = fmt == 2'b00 ? {opcode, reg1, reg2, shamt, 9'd0, fcode} :
          fmt == 2'b01 ? {opcode, reg1, 7'd0, imm} : {opcode, 2'd0, label};
`ifdef INSTR_ENC_CHECK_EN
    legal = fmt == 2'b00 ? !(fcode < 4'h8 && shamt != 5'd0) :
            fmt == 2'b01 ? reg2 == 5'd0 :
            fmt == 2'b10 ? reg1 == 5'd0 && reg2 == 5'd0 : 1'b0;
`else
    legal = fmt != 2'b11;
`endif
  end
  always_comb begin
    state_nx = state == IDLE ? (start ? (count != 10'd0 ? LOAD : DONE) : IDLE) :
               state == LOAD ? (xfer && rem == 10'd1 ? DONE : LOAD) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // words_written doubles as the write index: both clear on start and step on every legal write
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      base <= '0;
      rem <= '0;
      words_written <= '0;
      err <= 1'b0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= xfer && legal;
      if (state == IDLE && start) begin
        base <= base_addr;
        rem <= count;
        words_written <= '0;
        err <= 1'b0;
      end
      if (xfer) begin
        rem <= rem - 10'd1;
        if (legal) begin
          wr_addr <= base + words_written;
          wr_data <= enc;
          words_written <= words_written + 10'd1;
        end else err <= 1'b1;
      end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: table-driven, directed and randomized checks of instr_encoder_loader against a field-level model
module tb_instr_encoder_loader;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [9:0] base_addr = '0, count = '0;
  logic [1:0] fmt = '0;
  logic [3:0] opcode = '0, fcode = '0;
  logic [4:0] reg1 = '0, reg2 = '0, shamt = '0;
  logic [15:0] imm = '0;
  logic [25:0] label = '0;
  logic in_ready, wr_en, busy, done, err;
  logic [9:0] wr_addr, words_written;
  logic [31:0] wr_data;
  instr_encoder_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode), .fcode(fcode),
    .reg1(reg1), .reg2(reg2), .shamt(shamt), .imm(imm), .label(label),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .err(err), .words_written(words_written)
  );
  always #5 clk = ~clk;
  typedef struct {logic [1:0] fmt; logic [3:0] op, fc; logic [4:0] r1, r2, sh; logic [15:0] imm; logic [25:0] lab;} tup_t;
  typedef struct {tup_t t; logic [9:0] base; logic [31:0] data; int wr; bit err;} vec_t;
  typedef struct {logic [9:0] a; logic [31:0] d;} wr_t;
  tup_t tup[16];
  vec_t v[6];
  wr_t expq[$];
  int checks = 0, failures = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic bit legal_m(input tup_t t);
    if (t.fmt == 2'd3) return 1'b0;
`ifdef INSTR_ENC_CHECK_EN
    if (t.fmt == 2'd1 && t.r2 != 5'd0) return 1'b0;
    if (t.fmt == 2'd2 && (t.r1 != 5'd0 || t.r2 != 5'd0)) return 1'b0;
    if (t.fmt == 2'd0 && t.fc < 4'd8 && t.sh != 5'd0) return 1'b0;
`endif
    return 1'b1;
  endfunction
  function automatic logic [31:0] enc_m(input tup_t t);
    logic [31:0] w;
    w = 32'(t.op) << 28;
    if (t.fmt == 2'd0) w = w + (32'(t.r1) << 23) + (32'(t.r2) << 18) + (32'(t.sh) << 13) + 32'(t.fc);
    else if (t.fmt == 2'd1) w = w + (32'(t.r1) << 23) + 32'(t.imm);
    else w = w + 32'(t.lab);
    return w;
  endfunction
  task automatic apply(input tup_t t);
    fmt = t.fmt; opcode = t.op; fcode = t.fc; reg1 = t.r1; reg2 = t.r2; shamt = t.sh; imm = t.imm; label = t.lab;
  endtask
  always @(negedge clk)
    if (wr_en) begin
      wr_t e;
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got wr_en addr %0h data %0h expected no write", wr_addr, wr_data);
      end else begin
        e = expq.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.a));
        chk("wr_data", wr_data, e.d);
      end
    end
  task automatic do_load(input logic [9:0] b, input int n, input bit gaps);
    int i = 0, cyc = 0, w = 0;
    bit e = 1'b0, acc;
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; count = 10'(n);
    @(posedge clk); #1;
    start = 1'b0;
    while (i < n && cyc < 200) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      apply(tup[i]);
      @(negedge clk);
      chk("in_ready_load", 32'(in_ready), 32'd1);
      acc = in_valid;
      @(posedge clk);
      if (acc) begin
        if (legal_m(tup[i])) begin
          expq.push_back('{a: 10'(b + 10'(w)), d: enc_m(tup[i])});
          w++;
        end else e = 1'b1;
        i++;
      end
      cyc++;
      #1;
    end
    in_valid = 1'b0;
    if (i < n) chk("load_timeout", 32'(i), 32'(n));
    if (!gaps) chk("back_to_back_cycles", 32'(cyc), 32'(n));
    @(negedge clk);
    chk("done_end", 32'(done), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk("in_ready_end", 32'(in_ready), 32'd0);
    chk("words_written_end", 32'(words_written), 32'(w));
    chk("err_end", 32'(err), 32'(e));
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    v[0] = '{'{2'd0, 4'h0, 4'h1, 5'd3, 5'd4, 5'd0, 16'hFFFF, 26'h3FFFFFF}, 10'h010, 32'h01900001, 1, 1'b0};
    v[1] = '{'{2'd1, 4'h5, 4'hF, 5'd31, 5'd0, 5'd31, 16'h1234, 26'h3FFFFFF}, 10'h3FF, 32'h5F801234, 1, 1'b0};
    v[2] = '{'{2'd2, 4'hF, 4'hF, 5'd0, 5'd0, 5'd31, 16'hFFFF, 26'h3FFFFFF}, 10'h000, 32'hF3FFFFFF, 1, 1'b0};
    v[3] = '{'{2'd3, 4'h7, 4'h3, 5'd1, 5'd2, 5'd3, 16'h0101, 26'h0000101}, 10'h100, 32'h0, 0, 1'b1};
    v[4] = '{'{2'd0, 4'hA, 4'hF, 5'd31, 5'd31, 5'd31, 16'h0000, 26'h0}, 10'h200, 32'hAFFFE00F, 1, 1'b0};
`ifdef INSTR_ENC_CHECK_EN
    v[5] = '{'{2'd2, 4'h2, 4'h0, 5'd1, 5'd0, 5'd0, 16'h0, 26'h0000ABC}, 10'h055, 32'h0, 0, 1'b1};
`else
    v[5] = '{'{2'd2, 4'h2, 4'h0, 5'd1, 5'd0, 5'd0, 16'h0, 26'h0000ABC}, 10'h055, 32'h20000ABC, 1, 1'b0};
`endif
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_words_written", 32'(words_written), 32'd0);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tup[0] = v[k].t;
      do_load(v[k].base, 1, 1'b0);
      if (v[k].wr != 0) begin
        chk("vec_wr_data", wr_data, v[k].data);
        chk("vec_wr_addr", 32'(wr_addr), 32'(v[k].base));
      end
      chk("vec_words_written", 32'(words_written), 32'(v[k].wr));
      chk("vec_err", 32'(err), 32'(v[k].err));
    end
    for (int i = 0; i < 3; i++) tup[i] = '{2'd1, 4'h1, 4'h0, 5'd2, 5'd0, 5'd0, 16'h1234, 26'h0};
    do_load(10'h3FE, 3, 1'b0);
    chk("wrap_last_addr", 32'(wr_addr), 32'h000);
    chk("wrap_words_written", 32'(words_written), 32'd3);
    do_load(10'h0AA, 0, 1'b0);
    chk("zero_words_written", 32'(words_written), 32'd0);
    tup[0] = '{2'd3, 4'h9, 4'h1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1};
    tup[1] = '{2'd2, 4'h6, 4'h0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000ABC};
    do_load(10'h123, 2, 1'b0);
    chk("rsv_wr_data", wr_data, 32'h60000ABC);
    chk("rsv_wr_addr", 32'(wr_addr), 32'h123);
    chk("rsv_words_written", 32'(words_written), 32'd1);
    chk("rsv_err", 32'(err), 32'd1);
    for (int i = 0; i < 5; i++) tup[i] = '{2'd0, 4'h3, 4'h9, 5'(i), 5'd7, 5'd2, 16'h0, 26'h0};
    @(posedge clk); #1;
    start = 1'b1; base_addr = 10'h040; count = 10'd5;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      apply(tup[i]);
      @(posedge clk);
      expq.push_back('{a: 10'h040 + 10'(i), d: enc_m(tup[i])});
      #1;
    end
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    expq.delete();
    #1;
    chk("abort_wr_en", 32'(wr_en), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_wr_data", wr_data, 32'd0);
    chk("abort_words_written", 32'(words_written), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_idle_busy", 32'(busy), 32'd0);
    chk("abort_idle_done", 32'(done), 32'd0);
    for (int r = 0; r < 25; r++) begin
      int n;
      n = (r % 8 == 7) ? 0 : int'($urandom_range(1, 10));
      for (int i = 0; i < n; i++)
        tup[i] = '{2'($urandom), 4'($urandom), 4'($urandom), 5'($urandom), 5'($urandom % 2 == 0 ? 0 : $urandom),
                   5'($urandom), 16'($urandom), 26'($urandom)};
      do_load(10'($urandom), n, 1'b1);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
